ans_ht_ltf_buffer: RTL

Capture-and-replay buffer directly downstream of `ans_ht_ltf_generator` in the openofdm_tx chain. On a TX request it latches the 128-bit obfuscation coefficients, kicks the generator, and captures the 80-sample HT-LTF burst (16 CP + 64) into local storage. It then replays the burst to the dot11 TX mux over a valid/ready stream, so the mux can stall without losing samples.

---
 rtl/ans_ht_ltf_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ans_ht_ltf_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ans_ht_ltf_buffer
// Description : Capture-and-replay buffer for one HT-LTF burst. An accepted
//               TX request latches the obfuscation coefficients, kicks the
//               generator, captures the burst into local storage, and replays
//               it over a valid/ready stream so the consumer may stall.
// Ports       : clk, reset            - clock, async active-high reset
//               tx_start, abort       - request / synchronous flush
//               obf_coeff_in          - coefficients sampled on request
//               gen_obf_coeff         - latched coefficients to generator
//               gen_letsgo            - one-cycle generator kick
//               gen_givemeoutput      - high while waiting for / capturing data
//               ans_ht_ltf            - generator sample (I[31:16], Q[15:0])
//               ans_ht_ltf_started    - marks sample 0 of the burst
//               out_data/valid/ready/last - replay stream
//               busy                  - not idle
//               timeout_err           - sticky generator-start timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module ans_ht_ltf_buffer #(
    parameter int N_SAMPLES      = 80,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_start,
    input  logic         abort,
    input  logic [127:0] obf_coeff_in,
    output logic [127:0] gen_obf_coeff,
    output logic         gen_letsgo,
    output logic         gen_givemeoutput,
    input  logic [31:0]  ans_ht_ltf,
    input  logic         ans_ht_ltf_started,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         timeout_err
);

    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_KICK    = 3'd1;
    localparam logic [2:0] S_ARM     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_PLAY    = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [127:0]     coeff_q,  coeff_d;
    logic             err_q,    err_d;

    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_waddr;

    logic [31:0]      mem [N_SAMPLES];

    // ------------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            coeff_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
            coeff_q  <= coeff_d;
            err_q    <= err_d;
        end
    end

    // Sample storage carries no reset; contents are simply overwritten by the
    // next capture and never observed outside PLAY.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_waddr] <= ans_ht_ltf;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        cnt_d       = cnt_q;
        coeff_d     = coeff_q;
        err_d       = err_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = wr_idx_q;

        if (abort) begin
            // Flush wins over everything; coefficients and error flag persist.
            state_d  = S_IDLE;
            wr_idx_d = '0;
            rd_idx_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        coeff_d = obf_coeff_in;
                        err_d   = 1'b0;
                        state_d = S_KICK;
                    end
                end
                S_KICK: begin
                    cnt_d    = '0;
                    wr_idx_d = '0;
                    state_d  = S_ARM;
                end
                S_ARM: begin
                    if (ans_ht_ltf_started) begin
                        // Sample 0 arrives together with the start marker.
                        w_mem_we    = 1'b1;
                        w_mem_waddr = '0;
                        wr_idx_d    = IDX_W'(1);
                        cnt_d       = '0;
                        state_d     = S_CAPTURE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    w_mem_we = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        state_d  = S_PLAY;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (out_ready) begin
                        if (rd_idx_q == LAST_IDX) begin
                            rd_idx_d = '0;
                            state_d  = S_IDLE;
                        end else begin
                            rd_idx_d = rd_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from registered state only so that an asynchronous
    // reset drives them to zero immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        gen_obf_coeff    = coeff_q;
        timeout_err      = err_q;
        gen_letsgo       = (state_q == S_KICK);
        gen_givemeoutput = (state_q == S_ARM) || (state_q == S_CAPTURE);
        busy             = (state_q != S_IDLE);
        out_valid        = (state_q == S_PLAY);
        out_last         = (state_q == S_PLAY) && (rd_idx_q == LAST_IDX);
        // Gate storage so the stream reads zero whenever nothing is offered.
        out_data         = (state_q == S_PLAY) ? mem[rd_idx_q] : 32'd0;
    end

endmodule
`default_nettype wire
